// File: rtl/trace_frame_tx_pkg.sv
// Shared definitions for trace_frame_tx: FSM state encoding, default record geometry and sync byte.
package trace_frame_tx_pkg;

    localparam int          PT_BYTES_DEF  = 4;
    localparam int          KEY_BYTES_DEF = 8;
    localparam int          CT_BYTES_DEF  = 4;
    localparam int          SAMPLES_DEF   = 1024;
    localparam int          ADDR_W_DEF    = 10;
    localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_NEXT   = 3'd3,
        ST_FETCH  = 3'd4,
        ST_FETCH2 = 3'd5,
        ST_TAIL   = 3'd6,
        ST_DONE   = 3'd7
    } state_e;

endpackage

// File: rtl/trace_frame_tx_if.sv
// Byte handshake between trace_frame_tx (master) and uart_tx (slave).
interface trace_frame_tx_if;
    // tx_dv is a 1-cycle strobe qualifying tx_byte; tx_byte stays stable until the next
    // strobe; tx_done is a 1-cycle pulse from the UART once that byte has been shifted out.
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       tx_done;

    modport master (output tx_dv, output tx_byte, input tx_done);
    modport slave  (input tx_dv, input tx_byte, output tx_done);
endinterface

// File: rtl/trace_frame_tx.sv
// Serialises one capture record (sync, PT, key, CT, trace samples) to the uart_tx handshake.
// Optional FRAME_CHECKSUM_EN appends a running XOR of all sent bytes as a final record byte.
module trace_frame_tx
    import trace_frame_tx_pkg::*;
#(
    parameter int         PT_BYTES  = PT_BYTES_DEF,
    parameter int         KEY_BYTES = KEY_BYTES_DEF,
    parameter int         CT_BYTES  = CT_BYTES_DEF,
    parameter int         SAMPLES   = SAMPLES_DEF,
    parameter int         ADDR_W    = ADDR_W_DEF,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic [PT_BYTES*8-1:0]  pt,
    input  logic [KEY_BYTES*8-1:0] key,
    input  logic [CT_BYTES*8-1:0]  ct,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic [7:0]             mem_rdata,
    trace_frame_tx_if.master       uart,
    output logic                   busy,
    output logic                   done,
    output state_e                 dbg_state
);

    localparam int H     = 1 + PT_BYTES + KEY_BYTES + CT_BYTES;
    localparam int IDX_W = $clog2(H + SAMPLES + 2);
    localparam int HDR_W = H * 8;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       byte_idx_q, byte_idx_d;
    logic [PT_BYTES*8-1:0]  pt_q, pt_d;
    logic [KEY_BYTES*8-1:0] key_q, key_d;
    logic [CT_BYTES*8-1:0]  ct_q, ct_d;
    logic                   tx_dv_q, tx_dv_d;
    logic [7:0]             tx_byte_q, tx_byte_d;
    logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [HDR_W-1:0]       hdr;
    logic [7:0]             hdr_byte;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]             csum_q, csum_d;
`endif

    assign hdr = {SYNC_BYTE, pt_q, key_q, ct_q};

    // Header byte k sits k bytes below the MSB of {sync, pt, key, ct}.
    always_comb begin
        hdr_byte = '0;
        for (int i = 0; i < H; i++) begin
            if (byte_idx_q == IDX_W'(i)) hdr_byte = hdr[(H-1-i)*8 +: 8];
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        pt_d       = pt_q;
        key_d      = key_q;
        ct_d       = ct_q;
        tx_dv_d    = 1'b0;
        tx_byte_d  = tx_byte_q;
        mem_addr_d = mem_addr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
`ifdef FRAME_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pt_d       = pt;
                    key_d      = key;
                    ct_d       = ct;
                    busy_d     = 1'b1;
                    byte_idx_d = '0;
`ifdef FRAME_CHECKSUM_EN
                    csum_d     = '0;
`endif
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                tx_byte_d = hdr_byte;
                tx_dv_d   = 1'b1;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (uart.tx_done) begin
                    byte_idx_d = byte_idx_q + 1'b1;
                    state_d    = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (byte_idx_q < IDX_W'(H)) begin
                    state_d = ST_LOAD;
                end else if (byte_idx_q < IDX_W'(H + SAMPLES)) begin
                    // Address goes out while entering FETCH so the 1-cycle RAM data is ready in FETCH2.
                    mem_addr_d = ADDR_W'(byte_idx_q - IDX_W'(H));
                    state_d    = ST_FETCH;
`ifdef FRAME_CHECKSUM_EN
                end else if (byte_idx_q == IDX_W'(H + SAMPLES)) begin
                    state_d = ST_TAIL;
                end else begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                end
`else
                end else begin
                    state_d = ST_TAIL;
                end
`endif
            end
            ST_FETCH: begin
                state_d = ST_FETCH2;
            end
            ST_FETCH2: begin
                tx_byte_d = mem_rdata;
                tx_dv_d   = 1'b1;
                state_d   = ST_WAIT;
            end
            ST_TAIL: begin
`ifdef FRAME_CHECKSUM_EN
                tx_byte_d = csum_q;
                tx_dv_d   = 1'b1;
                state_d   = ST_WAIT;
`else
                done_d    = 1'b1;
                busy_d    = 1'b0;
                state_d   = ST_DONE;
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef FRAME_CHECKSUM_EN
        // The checksum byte itself is not folded into the running XOR.
        if (tx_dv_d && state_q != ST_TAIL) csum_d = csum_q ^ tx_byte_d;
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            byte_idx_q <= '0;
            pt_q       <= '0;
            key_q      <= '0;
            ct_q       <= '0;
            tx_dv_q    <= 1'b0;
            tx_byte_q  <= '0;
            mem_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            pt_q       <= pt_d;
            key_q      <= key_d;
            ct_q       <= ct_d;
            tx_dv_q    <= tx_dv_d;
            tx_byte_q  <= tx_byte_d;
            mem_addr_q <= mem_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef FRAME_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign uart.tx_dv   = tx_dv_q;
    assign uart.tx_byte = tx_byte_q;
    assign mem_addr     = mem_addr_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_trace_frame_tx.sv
// Bench for trace_frame_tx: UART model with 3-cycle done latency, trace RAM model, byte scoreboard.
module tb_trace_frame_tx;
    import trace_frame_tx_pkg::*;

    localparam int SAMPLES = 8;
    localparam int ADDR_W  = 3;
    localparam int H       = 17;
`ifdef FRAME_CHECKSUM_EN
    localparam int REC_LEN = H + SAMPLES + 1;
`else
    localparam int REC_LEN = H + SAMPLES;
`endif

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               start = 1'b0;
    logic [31:0]        pt = '0;
    logic [63:0]        key = '0;
    logic [31:0]        ct = '0;
    logic [ADDR_W-1:0]  mem_addr;
    logic [7:0]         mem_rdata = '0;
    logic               busy;
    logic               done;
    state_e             dbg_state;
    logic [7:0]         ram [SAMPLES];

    trace_frame_tx_if ifc ();

    trace_frame_tx #(.SAMPLES(SAMPLES), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rstn(rstn), .start(start), .pt(pt), .key(key), .ct(ct),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .uart(ifc),
        .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    always @(posedge clk) mem_rdata <= ram[mem_addr];

    // Scoreboard state
    logic [7:0] exp_q[$];
    int         vectors     = 0;
    int         miscompares = 0;
    int         bytes_seen  = 0;
    int         done_cnt    = 0;
    bit         stall       = 1'b0;
    bit         abort_byte  = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // UART model: tx_done pulses 3 cycles after tx_dv, held off while stall is set.
    initial begin
        ifc.tx_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rstn && ifc.tx_dv) begin
                abort_byte = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(posedge clk); #1;
                    if (!rstn) abort_byte = 1'b1;
                end
                while (stall && !abort_byte) begin
                    @(posedge clk); #1;
                    if (!rstn) abort_byte = 1'b1;
                end
                if (!abort_byte && rstn) begin
                    ifc.tx_done = 1'b1;
                    @(posedge clk); #1;
                    ifc.tx_done = 1'b0;
                end
            end
        end
    end

    // Monitor: every tx_dv pops one expected byte.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (done) done_cnt++;
            if (ifc.tx_dv) begin
                bytes_seen++;
                if (exp_q.size() == 0) check_val("extra_tx_dv", 64'(ifc.tx_byte), 64'hxx);
                else check_val($sformatf("byte%0d", bytes_seen), 64'(ifc.tx_byte), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic push_record(input logic [31:0] p, input logic [63:0] k, input logic [31:0] c);
        logic [7:0] rec[$];
        logic [7:0] x;
        rec.push_back(8'hA5);
        for (int i = 3; i >= 0; i--) rec.push_back(p[i*8 +: 8]);
        for (int i = 7; i >= 0; i--) rec.push_back(k[i*8 +: 8]);
        for (int i = 3; i >= 0; i--) rec.push_back(c[i*8 +: 8]);
        for (int i = 0; i < SAMPLES; i++) rec.push_back(ram[i]);
        x = '0;
        foreach (rec[i]) begin
            x = x ^ rec[i];
            exp_q.push_back(rec[i]);
        end
`ifdef FRAME_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    task automatic pulse_start(input logic [31:0] p, input logic [63:0] k, input logic [31:0] c);
        @(posedge clk); #1;
        pt = p; key = k; ct = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        bit seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(posedge clk); #2;
            if (done) seen = 1'b1;
        end
        check_val({tag, "_done_seen"}, 64'(seen), 64'd1);
        repeat (3) @(posedge clk);
        #2;
        check_val({tag, "_done_once"}, 64'(done_cnt), 64'd1);
        check_val({tag, "_busy_low"}, 64'(busy), 64'd0);
        check_val({tag, "_bytes"}, 64'(bytes_seen), 64'(REC_LEN));
        check_val({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run_record(input string tag, input logic [31:0] p, input logic [63:0] k,
                              input logic [31:0] c);
        bytes_seen = 0;
        done_cnt   = 0;
        push_record(p, k, c);
        pulse_start(p, k, c);
        check_val({tag, "_busy_start"}, 64'(busy), 64'd1);
        wait_done(tag, 2000);
    endtask

    initial begin
        bit byte_moved;
        bit busy_drop;
        bit seen;
        for (int i = 0; i < SAMPLES; i++) ram[i] = 8'(i + 1);

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_tx_dv", 64'(ifc.tx_dv), 64'd0);
        check_val("rst_tx_byte", 64'(ifc.tx_byte), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_mem_addr", 64'(mem_addr), 64'd0);
        check_val("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        rstn = 1'b1;
        repeat (2) @(posedge clk);

        // Reference record
        run_record("ref", 32'h65656877, 64'h1918111009080100, 32'hC69BE9BB);

        // Second start mid-record must not restart it
        bytes_seen = 0;
        done_cnt   = 0;
        push_record(32'h65656877, 64'h1918111009080100, 32'hC69BE9BB);
        pulse_start(32'h65656877, 64'h1918111009080100, 32'hC69BE9BB);
        repeat (20) @(posedge clk);
        pulse_start(32'h11111111, 64'h2222222222222222, 32'h33333333);
        wait_done("restart", 2000);

        // Marker bytes 250/253 pass through unchanged; other fields random
        for (int i = 0; i < SAMPLES; i++) ram[i] = 8'($urandom_range(0, 255));
        ram[0] = 8'd250;
        ram[SAMPLES-1] = 8'd253;
        run_record("marker", $urandom, {$urandom, $urandom}, $urandom);

        // Reset while byte 10 is on the wire
        bytes_seen = 0;
        push_record(32'h65656877, 64'h1918111009080100, 32'hC69BE9BB);
        pulse_start(32'h65656877, 64'h1918111009080100, 32'hC69BE9BB);
        seen = 1'b0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(posedge clk); #2;
            if (bytes_seen >= 10) seen = 1'b1;
        end
        check_val("mid_rst_reached_byte10", 64'(seen), 64'd1);
        rstn = 1'b0;
        #1;
        check_val("mid_rst_tx_dv", 64'(ifc.tx_dv), 64'd0);
        check_val("mid_rst_busy", 64'(busy), 64'd0);
        check_val("mid_rst_done", 64'(done), 64'd0);
        check_val("mid_rst_state", 64'(dbg_state), 64'(ST_IDLE));
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (2) @(posedge clk);
        run_record("after_rst", 32'h65656877, 64'h1918111009080100, 32'hC69BE9BB);

        // Stalled tx_done
        bytes_seen = 0;
        done_cnt   = 0;
        stall      = 1'b1;
        push_record(32'hDEADBEEF, 64'h0123456789ABCDEF, 32'hCAFEF00D);
        pulse_start(32'hDEADBEEF, 64'h0123456789ABCDEF, 32'hCAFEF00D);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk); #2;
            if (bytes_seen >= 1) seen = 1'b1;
        end
        check_val("stall_first_dv", 64'(seen), 64'd1);
        byte_moved = 1'b0;
        busy_drop  = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #2;
            if (ifc.tx_byte !== 8'hA5) byte_moved = 1'b1;
            if (busy !== 1'b1) busy_drop = 1'b1;
        end
        check_val("stall_byte_moved", 64'(byte_moved), 64'd0);
        check_val("stall_busy_drop", 64'(busy_drop), 64'd0);
        check_val("stall_dv_count", 64'(bytes_seen), 64'd1);
        stall = 1'b0;
        wait_done("stall", 2000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

endmodule
